// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 write-only register block.
// The external sclk/copi/ncs pins are resynchronised into the clk domain.
// 16-bit frames {rw, addr[6:0], data[7:0]} are assembled MSB first, and each
// valid write frame is committed to one of five 8-bit control registers that
// feed the PWM/output stage.
module spi_reg_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe
);

  localparam int         NUM_REGS   = 5;
  localparam logic [6:0] MAX_ADDR_L = 7'(MAX_ADDR);

  typedef enum logic {IDLE, SHIFT} state_t;

  // Synchroniser chains and previous-value flops used for edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
  logic [SYNC_STAGES-1:0] ncs_sync_q,  ncs_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ncs_prev_q,  ncs_prev_d;

  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, ncs_rise, ncs_fall;

  // Frame assembly and register state
  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [15:0] shift_q, shift_d;
  logic [7:0]  regs_q [NUM_REGS];
  logic [7:0]  regs_d [NUM_REGS];
  logic        strobe_q, strobe_d;
  logic        commit_ok;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q;

  // Next values of the synchroniser chains: raw pin enters at bit 0
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
    ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs};
    sclk_prev_d = sclk_s;
    ncs_prev_d  = ncs_s;
  end

  // Synchroniser and edge-detect flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      copi_sync_q <= copi_sync_d;
      ncs_sync_q  <= ncs_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ncs_prev_q  <= ncs_prev_d;
    end
  end

  // A frame is committed only when exactly 16 bits arrived, it is a write,
  // and the address names an existing register.
  assign commit_ok = (count_q == 5'd16) && shift_q[15] &&
                     (shift_q[14:8] <= MAX_ADDR_L);

  // Frame FSM next-state: ncs edges take priority over a coincident sclk edge
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shift_d  = shift_q;
    strobe_d = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
    case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          count_d = '0;
          shift_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ncs_rise) begin
          state_d = IDLE;
          if (commit_ok) begin
            strobe_d = 1'b1;
            for (int i = 0; i < NUM_REGS; i++) begin
              if (shift_q[14:8] == 7'(i)) regs_d[i] = shift_q[7:0];
            end
          end
        end else if (sclk_rise) begin
          shift_d = {shift_q[14:0], copi_s};
          // 17 marks an over-length frame; holding it there keeps it invalid
          if (count_q != 5'd17) count_d = count_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame FSM state, shift register, control registers and strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      shift_q  <= '0;
      strobe_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shift_q  <= shift_d;
      strobe_q <= strobe_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign wr_strobe       = strobe_q;

endmodule
